// File: rtl/easyaxi_rd_mst.sv
// easyaxi_rd_mst: AXI4 read-channel traffic master.
// Issues NUM_TXN INCR bursts, checks every returned beat against an
// address-as-data pattern, and reports done plus a sticky err flag.
module easyaxi_rd_mst #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    BURST_LEN  = 8,
  parameter int                    NUM_TXN    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  axi_mst_arvalid,
  input  logic                  axi_mst_arready,
  output logic [ID_WIDTH-1:0]   axi_mst_arid,
  output logic [ADDR_WIDTH-1:0] axi_mst_araddr,
  output logic [7:0]            axi_mst_arlen,
  output logic [2:0]            axi_mst_arsize,
  output logic [1:0]            axi_mst_arburst,
  input  logic                  axi_mst_rvalid,
  output logic                  axi_mst_rready,
  input  logic [ID_WIDTH-1:0]   axi_mst_rid,
  input  logic [DATA_WIDTH-1:0] axi_mst_rdata,
  input  logic [1:0]            axi_mst_rresp,
  input  logic                  axi_mst_rlast,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            txn_cnt
);

  localparam int                    BYTES     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] BEAT_INC  = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_LEN * BYTES);
  localparam logic [7:0]            LEN       = 8'(BURST_LEN - 1);
  localparam logic [2:0]            SIZE      = 3'($clog2(BYTES));
  localparam logic [7:0]            LAST_TXN  = 8'(NUM_TXN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [ID_WIDTH-1:0]     arid_q;
  logic [ADDR_WIDTH-1:0]   exp_addr_q;
  logic [7:0]              beat_q;
  logic                    done_q;
  logic                    err_q;
  logic [7:0]              txn_cnt_q;

  logic                    beat_last_s;
  logic                    beat_bad_s;
  logic [DATA_WIDTH-1:0]   exp_data_s;

  // Zero-extend or truncate an address to the data width.
  function automatic logic [DATA_WIDTH-1:0] addr_to_data(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    return ext[DATA_WIDTH-1:0];
  endfunction

  // Per-beat checks: expected data, OKAY response, matching ID, rlast only on the final beat.
  always_comb begin
    beat_last_s = (beat_q == LEN);
    exp_data_s  = addr_to_data(exp_addr_q);
    beat_bad_s  = (axi_mst_rdata != exp_data_s) ||
                  (axi_mst_rresp != 2'b00) ||
                  (axi_mst_rid != arid_q) ||
                  (axi_mst_rlast != beat_last_s);
  end

  // Run sequencer: IDLE -> (AR -> R) x NUM_TXN -> DONE, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= BASE_ADDR;
      arid_q     <= {ID_WIDTH{1'b0}};
      exp_addr_q <= BASE_ADDR;
      beat_q     <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      txn_cnt_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR;
            arid_q    <= {ID_WIDTH{1'b0}};
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            txn_cnt_q <= 8'd0;
          end
        end
        ST_AR: begin
          // Address stays put until accepted; arvalid never retracts.
          if (arvalid_q && axi_mst_arready) begin
            state_q    <= ST_R;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            beat_q     <= 8'd0;
            exp_addr_q <= araddr_q;
          end
        end
        ST_R: begin
          if (axi_mst_rvalid && rready_q) begin
            if (beat_bad_s) begin
              err_q <= 1'b1;
            end
            // Burst length is counted; rlast is only checked, never trusted.
            if (beat_last_s) begin
              rready_q  <= 1'b0;
              beat_q    <= 8'd0;
              txn_cnt_q <= txn_cnt_q + 8'd1;
              if (txn_cnt_q == LAST_TXN) begin
                state_q  <= ST_DONE;
                done_q   <= 1'b1;
                araddr_q <= BASE_ADDR;
                arid_q   <= {ID_WIDTH{1'b0}};
              end else begin
                state_q   <= ST_AR;
                arvalid_q <= 1'b1;
                araddr_q  <= araddr_q + BURST_INC;
                arid_q    <= arid_q + ID_WIDTH'(1'b1);
              end
            end else begin
              beat_q     <= beat_q + 8'd1;
              exp_addr_q <= exp_addr_q + BEAT_INC;
            end
          end
        end
        ST_DONE: begin
          // Hold done until enable drops; never restart on our own.
          if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_arid    = arid_q;
  assign axi_mst_araddr  = araddr_q;
  assign axi_mst_arlen   = LEN;
  assign axi_mst_arsize  = SIZE;
  assign axi_mst_arburst = 2'b01;
  assign axi_mst_rready  = rready_q;
  assign done            = done_q;
  assign err             = err_q;
  assign txn_cnt         = txn_cnt_q;

endmodule
